range_speed_sequencer: RTL and testbench
========================================

RANGE_SPEED_SEQUENCER -- requirements
Module: range_speed_sequencer

Interface
REQ-001 Parameter TRIG_CYCLES, default 1000: trig high time in clk cycles (10 us at 100 MHz).
REQ-002 Parameter ECHO_TIMEOUT, default 3_802_000: maximum wait for echo rise, and maximum echo high time, in cycles.
REQ-003 Parameter BIN_STEP, default 475_250: echo-width bin size in cycles.
REQ-004 Parameter HOLDOFF_CYCLES, default 6_000_000: idle gap after each measurement (60 ms).
REQ-005 Parameter PWM_PERIOD, default 250_000: PWM carrier period in cycles (400 Hz); must fit in 19 bits.
REQ-006 clk  input  1  100 MHz system clock; all state changes on posedge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 run  input  1  enables ranging; synchronous, level-sensitive.
REQ-009 echo  input  1  ultrasonic echo; asynchronous, 2-flop synchronized internally.
REQ-010 oc_fault  input  1  overcurrent sense (high = fault); asynchronous, 2-flop synchronized.
REQ-011 oc_clear  input  1  fault reset switch; asynchronous, 2-flop synchronized.
REQ-012 trig  output  1  ultrasonic trigger pulse.
REQ-013 pulse_width  output  19  PWM compare value for both motor channels.
REQ-014 range_bin  output  2  last distance bin (0 = nearest).
REQ-015 meas_valid  output  1  one-cycle strobe when pulse_width/range_bin update.
REQ-016 timeout  output  1  set with meas_valid when no echo or echo too long; cleared on next meas_valid.
REQ-017 fault_latched  output  1  high while in FAULT.

Function
REQ-018 States: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF, FAULT; one state register, registered outputs.
REQ-019 IDLE: trig=0; run=1 -> TRIG next cycle.
REQ-020 TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO with trig=0.
REQ-021 WAIT_ECHO: synced echo rise -> MEASURE, counter cleared; ECHO_TIMEOUT cycles without rise -> timeout result.
REQ-022 MEASURE: counter increments each cycle echo_sync=1; echo_sync fall -> bin result; counter reaching ECHO_TIMEOUT -> timeout result.
REQ-023 Bin result: count <= BIN_STEP -> bin 0; <= 2*BIN_STEP -> bin 1; <= 3*BIN_STEP -> bin 2; else bin 3; boundaries inclusive to the lower bin.
REQ-024 pulse_width = (bin+1)*PWM_PERIOD/4: defaults 62_500, 125_000, 187_500, 250_000.
REQ-025 Timeout result: range_bin=3, pulse_width=PWM_PERIOD, timeout=1.
REQ-026 Any result: pulse_width, range_bin, timeout and meas_valid=1 update on the same edge; state -> HOLDOFF.
REQ-027 HOLDOFF: count HOLDOFF_CYCLES, then TRIG if run=1, else IDLE.
REQ-028 run=0 in TRIG/WAIT_ECHO/MEASURE/HOLDOFF -> IDLE next cycle; trig=0, pulse_width=0, no meas_valid.
REQ-029 oc_fault_sync=1 in any state -> FAULT next cycle; pulse_width=0, trig=0, fault_latched=1; priority over run, echo fall and timeout on the same cycle.
REQ-030 FAULT exits to IDLE only when oc_clear_sync=1 and oc_fault_sync=0 together; pulse_width stays 0 until the next result.
REQ-031 Counters saturate, never wrap; echo already high when entering WAIT_ECHO is ignored until it falls and rises again.

Reset
REQ-032 rst_n=0 forces IDLE, trig=0, pulse_width=0, range_bin=0, meas_valid=0, timeout=0, fault_latched=0, all counters and synchronizers 0, immediately and independent of clk.
REQ-033 Reset deassertion mid-operation restarts from IDLE; no partial result is ever reported.

Verification (bench overrides: TRIG_CYCLES=10, ECHO_TIMEOUT=400, BIN_STEP=100, HOLDOFF_CYCLES=50, PWM_PERIOD=1000)
REQ-034 run=1 after reset -> trig high exactly 10 cycles; echo high 150 cycles -> meas_valid once, range_bin=1, pulse_width=500, timeout=0.
REQ-035 Echo widths 100 and 101 cycles -> bins 0/pulse_width 250, then 1/500; 301 -> bin 3, pulse_width 1000.
REQ-036 No echo -> meas_valid 400 cycles after WAIT_ECHO entry, timeout=1, pulse_width=1000; echo stuck high -> same result.
REQ-037 oc_fault high during MEASURE -> pulse_width=0 and fault_latched=1 within 3 cycles; oc_clear with fault still high -> stays FAULT; fault low + oc_clear -> IDLE, then TRIG.
REQ-038 run dropped during HOLDOFF -> IDLE, pulse_width=0; rst_n pulsed during TRIG -> trig=0 asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/range_speed_sequencer_if.sv
// Signal bundle between the ranging/PWM sequencer and its surroundings.
// meas_valid is a one-cycle strobe with no ready: the consumer captures pulse_width, range_bin and timeout on that cycle.
interface range_speed_sequencer_if;
    logic        run;
    logic        echo;
    logic        oc_fault;
    logic        oc_clear;
    logic        trig;
    logic [18:0] pulse_width;
    logic [1:0]  range_bin;
    logic        meas_valid;
    logic        timeout;
    logic        fault_latched;
    logic [2:0]  state_dbg;

    modport master (
        output run, echo, oc_fault, oc_clear,
        input  trig, pulse_width, range_bin, meas_valid, timeout, fault_latched, state_dbg
    );

    modport slave (
        input  run, echo, oc_fault, oc_clear,
        output trig, pulse_width, range_bin, meas_valid, timeout, fault_latched, state_dbg
    );
endinterface

// File: rtl/range_speed_sequencer.sv
// Ultrasonic ranging sequencer: triggers a ping, times the echo, bins the distance
// and maps the bin to a motor PWM compare value, with an overcurrent fault lockout.
module range_speed_sequencer #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int ECHO_TIMEOUT   = 3_802_000,
    parameter int BIN_STEP       = 475_250,
    parameter int HOLDOFF_CYCLES = 6_000_000,
    parameter int PWM_PERIOD     = 250_000
) (
    input logic                    clk,
    input logic                    rst_n,
    range_speed_sequencer_if.slave bus
);
    localparam int MAX_A = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
    localparam int MAX_B = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
    localparam int MAX_C = (MAX_B > 3 * BIN_STEP) ? MAX_B : 3 * BIN_STEP;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] ECHO_LAST = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] BIN1_MAX  = CW'(BIN_STEP);
    localparam logic [CW-1:0] BIN2_MAX  = CW'(2 * BIN_STEP);
    localparam logic [CW-1:0] BIN3_MAX  = CW'(3 * BIN_STEP);
    localparam logic [CW-1:0] CNT_SAT   = '1;
    localparam logic [18:0]   PW_BIN0   = 19'((1 * PWM_PERIOD) / 4);
    localparam logic [18:0]   PW_BIN1   = 19'((2 * PWM_PERIOD) / 4);
    localparam logic [18:0]   PW_BIN2   = 19'((3 * PWM_PERIOD) / 4);
    localparam logic [18:0]   PW_FULL   = 19'(PWM_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          trig_q, trig_n;
    logic [18:0]   pw_q, pw_n;
    logic [1:0]    bin_q, bin_n;
    logic          to_q, to_n;
    logic          mv_q, mv_n;
    logic          fl_q, fl_n;

    logic echo_s1, echo_sync, echo_d;
    logic fault_s1, fault_sync;
    logic clear_s1, clear_sync;
    logic echo_rise;

    logic [1:0]  meas_bin;
    logic [18:0] meas_pw;
    logic        res_take, res_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1    <= 1'b0;
            echo_sync  <= 1'b0;
            echo_d     <= 1'b0;
            fault_s1   <= 1'b0;
            fault_sync <= 1'b0;
            clear_s1   <= 1'b0;
            clear_sync <= 1'b0;
        end else begin
            echo_s1    <= bus.echo;
            echo_sync  <= echo_s1;
            echo_d     <= echo_sync;
            fault_s1   <= bus.oc_fault;
            fault_sync <= fault_s1;
            clear_s1   <= bus.oc_clear;
            clear_sync <= clear_s1;
        end
    end

    // A rise needs a low sample first, so an echo already high on entry is ignored.
    assign echo_rise = echo_sync & ~echo_d;
    assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    always_comb begin
        if (cnt <= BIN1_MAX)      meas_bin = 2'd0;
        else if (cnt <= BIN2_MAX) meas_bin = 2'd1;
        else if (cnt <= BIN3_MAX) meas_bin = 2'd2;
        else                      meas_bin = 2'd3;
        case (meas_bin)
            2'd0:    meas_pw = PW_BIN0;
            2'd1:    meas_pw = PW_BIN1;
            2'd2:    meas_pw = PW_BIN2;
            default: meas_pw = PW_FULL;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        trig_n   = trig_q;
        pw_n     = pw_q;
        bin_n    = bin_q;
        to_n     = to_q;
        mv_n     = 1'b0;
        fl_n     = fl_q;
        res_take = 1'b0;
        res_to   = 1'b0;
        if (fault_sync) begin
            state_n = S_FAULT;
            cnt_n   = '0;
            trig_n  = 1'b0;
            pw_n    = '0;
            fl_n    = 1'b1;
        end else if (!bus.run && (state inside {S_TRIG, S_WAIT_ECHO, S_MEASURE, S_HOLDOFF})) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            trig_n  = 1'b0;
            pw_n    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        state_n = S_TRIG;
                        cnt_n   = '0;
                        trig_n  = 1'b1;
                    end
                end
                S_TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state_n = S_WAIT_ECHO;
                        cnt_n   = '0;
                        trig_n  = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                S_WAIT_ECHO: begin
                    if (echo_rise) begin
                        // The rise cycle is itself the first high cycle of the echo.
                        state_n = S_MEASURE;
                        cnt_n   = {{(CW-1){1'b0}}, 1'b1};
                    end else if (cnt == ECHO_LAST) begin
                        res_take = 1'b1;
                        res_to   = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                S_MEASURE: begin
                    if (!echo_sync) begin
                        res_take = 1'b1;
                    end else if (cnt == ECHO_LAST) begin
                        res_take = 1'b1;
                        res_to   = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                S_HOLDOFF: begin
                    // run is known high here; a low run already left for IDLE above.
                    if (cnt == HOLD_LAST) begin
                        state_n = S_TRIG;
                        cnt_n   = '0;
                        trig_n  = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                S_FAULT: begin
                    if (clear_sync) begin
                        state_n = S_IDLE;
                        fl_n    = 1'b0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
            if (res_take) begin
                state_n = S_HOLDOFF;
                cnt_n   = '0;
                mv_n    = 1'b1;
                to_n    = res_to;
                bin_n   = res_to ? 2'd3 : meas_bin;
                pw_n    = res_to ? PW_FULL : meas_pw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            trig_q <= 1'b0;
            pw_q   <= '0;
            bin_q  <= '0;
            to_q   <= 1'b0;
            mv_q   <= 1'b0;
            fl_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            trig_q <= trig_n;
            pw_q   <= pw_n;
            bin_q  <= bin_n;
            to_q   <= to_n;
            mv_q   <= mv_n;
            fl_q   <= fl_n;
        end
    end

    assign bus.trig          = trig_q;
    assign bus.pulse_width   = pw_q;
    assign bus.range_bin     = bin_q;
    assign bus.timeout       = to_q;
    assign bus.meas_valid    = mv_q;
    assign bus.fault_latched = fl_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_range_speed_sequencer.sv
// Bench for range_speed_sequencer: echo widths are scored against a distance-bin model,
// plus trigger length, timeout latency, fault lockout, run drop and asynchronous reset.
module tb_range_speed_sequencer;
    localparam int TRIG_CYCLES    = 10;
    localparam int ECHO_TIMEOUT   = 400;
    localparam int BIN_STEP       = 100;
    localparam int HOLDOFF_CYCLES = 50;
    localparam int PWM_PERIOD     = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    range_speed_sequencer_if bus();

    range_speed_sequencer #(
        .TRIG_CYCLES    (TRIG_CYCLES),
        .ECHO_TIMEOUT   (ECHO_TIMEOUT),
        .BIN_STEP       (BIN_STEP),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
        .PWM_PERIOD     (PWM_PERIOD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected {timeout, range_bin, pulse_width} for an echo lasting w cycles (0 = none).
    function automatic logic [21:0] model(input int w);
        int bin;
        if (w == 0 || w >= ECHO_TIMEOUT) return {1'b1, 2'd3, 19'(PWM_PERIOD)};
        bin = (w + BIN_STEP - 1) / BIN_STEP - 1;
        if (bin > 3) bin = 3;
        return {1'b0, 2'(bin), 19'((bin + 1) * PWM_PERIOD / 4)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.meas_valid === 1'b1) begin
            logic [21:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got timeout=%0d bin=%0d pw=%0d, required no result",
                         bus.timeout, bus.range_bin, bus.pulse_width);
            end else begin
                e = exp_q.pop_front();
                check("result_timeout", bus.timeout, e[21]);
                check("result_bin", bus.range_bin, e[20:19]);
                check("result_pw", bus.pulse_width, e[18:0]);
            end
        end
    end

    task automatic wait_trig_high(output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        while (bus.trig !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic do_measure(input int w, input bit stuck);
        bit ok;
        bit seen;
        int len;
        int n;
        int d;
        wait_trig_high(ok);
        check("trig_started", ok, 1);
        if (!ok) return;
        if (stuck) bus.echo = 1'b1;
        len = 0;
        while (bus.trig === 1'b1 && len < 100) begin
            @(negedge clk);
            len++;
        end
        check("trig_len", len, TRIG_CYCLES);
        exp_q.push_back(model(stuck ? ECHO_TIMEOUT : w));
        if (w == 0 || stuck) begin
            n = 0;
            while (bus.meas_valid !== 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("timeout_latency", n, ECHO_TIMEOUT);
            bus.echo = 1'b0;
        end else begin
            d = $urandom_range(0, 60);
            repeat (d) @(negedge clk);
            seen = 1'b0;
            bus.echo = 1'b1;
            for (int i = 0; i < w; i++) begin
                @(negedge clk);
                if (bus.meas_valid === 1'b1) seen = 1'b1;
            end
            bus.echo = 1'b0;
            n = 0;
            while (!seen && n < 1000) begin
                @(negedge clk);
                n++;
                if (bus.meas_valid === 1'b1) seen = 1'b1;
            end
            check("result_seen", seen, 1);
        end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit ok;
        int n;
        bus.run      = 1'b0;
        bus.echo     = 1'b0;
        bus.oc_fault = 1'b0;
        bus.oc_clear = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trig", bus.trig, 0);
        check("rst_pw", bus.pulse_width, 0);
        check("rst_bin", bus.range_bin, 0);
        check("rst_valid", bus.meas_valid, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_fault", bus.fault_latched, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_trig", bus.trig, 0);
        bus.run = 1'b1;

        do_measure(150, 1'b0);
        do_measure(100, 1'b0);
        do_measure(101, 1'b0);
        do_measure(301, 1'b0);
        do_measure(300, 1'b0);
        do_measure(0, 1'b0);
        do_measure(0, 1'b1);
        do_measure(399, 1'b0);
        do_measure(400, 1'b0);
        repeat (6) do_measure($urandom_range(1, 420), 1'b0);
        do_measure(250, 1'b0);

        // Overcurrent in the middle of an echo measurement.
        wait_trig_high(ok);
        check("fault_trig_started", ok, 1);
        n = 0;
        while (bus.trig === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.echo = 1'b1;
        repeat (20) @(negedge clk);
        bus.oc_fault = 1'b1;
        repeat (3) @(negedge clk);
        check("fault_pw", bus.pulse_width, 0);
        check("fault_latched", bus.fault_latched, 1);
        check("fault_trig", bus.trig, 0);
        bus.echo = 1'b0;
        bus.oc_clear = 1'b1;
        repeat (10) @(negedge clk);
        check("fault_held_by_fault", bus.fault_latched, 1);
        bus.oc_fault = 1'b0;
        n = 0;
        while (bus.fault_latched === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fault_exit", bus.fault_latched, 0);
        check("fault_exit_pw", bus.pulse_width, 0);
        bus.oc_clear = 1'b0;
        do_measure(250, 1'b0);

        // run dropped during the holdoff gap.
        repeat (10) @(negedge clk);
        bus.run = 1'b0;
        repeat (2) @(negedge clk);
        check("run_drop_pw", bus.pulse_width, 0);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.trig === 1'b1) n++;
        end
        check("run_drop_no_trig", n, 0);
        bus.run = 1'b1;

        // Asynchronous reset while the trigger is high.
        wait_trig_high(ok);
        check("rst_trig_started", ok, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_trig", bus.trig, 0);
        check("async_rst_pw", bus.pulse_width, 0);
        check("async_rst_bin", bus.range_bin, 0);
        check("async_rst_timeout", bus.timeout, 0);
        check("async_rst_valid", bus.meas_valid, 0);
        check("async_rst_fault", bus.fault_latched, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_measure(50, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
